// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory copy engine.
// Build option: DMEM_COPY_CSUM_EN adds the running checksum port.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    typedef logic [DMEM_ADDR_W-1:0] addr_t;
    typedef logic [DMEM_DATA_W-1:0] data_t;

endpackage

// File: rtl/dmem_copy_master.sv
// Sequential block-copy initiator for the single-port data memory.
// Build option: DMEM_COPY_CSUM_EN adds the csum output and its adder.
module dmem_copy_master
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    output logic              memread,
    output logic              memwrite,
    input  logic [DATA_W-1:0] readdata
`ifdef DMEM_COPY_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    localparam logic [ADDR_W:0]   LEN_ONE = 1;
    localparam logic [ADDR_W-1:0] IDX_ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] lm1_q, lm1_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] idx_nx;
    logic              busy_d, done_d;
    logic              rd_d, wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    assign idx_nx = idx_q + IDX_ONE;

    // Next state and next registered outputs, derived from the state being entered.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        lm1_d   = lm1_q;
        idx_d   = idx_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = address;
        wdata_d = writedata;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    lm1_d = ADDR_W'(len - LEN_ONE);
                    idx_d = '0;
                    if (len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD;
                        busy_d  = 1'b1;
                        rd_d    = 1'b1;
                        addr_d  = src_addr;
                    end
                end
            end
            RD: begin
                state_d = CAP;
                busy_d  = 1'b1;
            end
            CAP: begin
                state_d = WR;
                busy_d  = 1'b1;
                wr_d    = 1'b1;
                addr_d  = dst_q + idx_q;
                wdata_d = readdata;
            end
            WR: begin
                if (idx_q == lm1_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RD;
                    idx_d   = idx_nx;
                    busy_d  = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = src_q + idx_nx;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured request and registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            lm1_q     <= '0;
            idx_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            address   <= '0;
            writedata <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            lm1_q     <= lm1_d;
            idx_q     <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
            memread   <= rd_d;
            memwrite  <= wr_d;
            address   <= addr_d;
            writedata <= wdata_d;
        end
    end

`ifdef DMEM_COPY_CSUM_EN
    // Running sum of every word read; cleared on accept, held after done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state_q == IDLE && start) begin
            csum <= '0;
        end else if (state_q == CAP) begin
            csum <= csum + readdata;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_copy_master.sv
// Self-checking bench for dmem_copy_master with a behavioural memory.
// Build option: DMEM_COPY_CSUM_EN enables the checksum checks.
module tb_dmem_copy_master;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int MSZ = 1 << AW;

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   len;
        bit            noise;
        bit            poke;
        int            lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, memread, memwrite;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata = '0;
`ifdef DMEM_COPY_CSUM_EN
    logic [DW-1:0] csum;
`endif

    dmem_copy_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .address   (address),
        .writedata (writedata),
        .memread   (memread),
        .memwrite  (memwrite),
        .readdata  (readdata)
`ifdef DMEM_COPY_CSUM_EN
        ,
        .csum      (csum)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [MSZ];
    logic [DW-1:0] ref_mem [MSZ];
    int            ecnt = 0;
    int            n_rd = 0, n_wr = 0, n_both = 0;
    logic [AW-1:0] rd_q [$];
    logic [AW-1:0] wr_q [$];
    logic [AW-1:0] exp_rd [$];
    logic [AW-1:0] exp_wr [$];
    int            n_cmp = 0, n_err = 0;
    vec_t          tbl [7];

    // Memory with one-cycle read latency plus access monitor.
    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        if (memread && memwrite) n_both <= n_both + 1;
        if (memread) begin
            readdata <= mem[address];
            n_rd     <= n_rd + 1;
            rd_q.push_back(address);
        end
        if (memwrite) begin
            mem[address] <= writedata;
            n_wr         <= n_wr + 1;
            wr_q.push_back(address);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < MSZ; i++)
            if (mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    function automatic int q_diffs(input logic [AW-1:0] a [$],
                                   input logic [AW-1:0] b [$]);
        int d = 0;
        if (a.size() != b.size()) return 1 + a.size() + b.size();
        foreach (a[i]) if (a[i] !== b[i]) d++;
        return d;
    endfunction

    task automatic clear_mon();
        n_rd   <= 0;
        n_wr   <= 0;
        n_both <= 0;
        rd_q.delete();
        wr_q.delete();
    endtask

    task automatic run_copy(input vec_t v, input string tag);
        logic [DW-1:0] esum;
        logic [DW-1:0] val;
        logic [AW-1:0] a, w;
        int            k, de, bcnt;
        bit            seen;
        esum = '0;
        exp_rd.delete();
        exp_wr.delete();
        for (int n = 0; n < int'(v.len); n++) begin
            a = v.src + AW'(n);
            w = v.dst + AW'(n);
            val = ref_mem[a];
            esum += val;
            ref_mem[w] = val;
            exp_rd.push_back(a);
            exp_wr.push_back(w);
        end
        @(negedge clk);
        clear_mon();
        src_addr = v.src;
        dst_addr = v.dst;
        len      = v.len;
        start    = 1'b1;
        k        = ecnt + 1;
        @(negedge clk);
        start    = 1'b0;
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        len      = (AW+1)'($urandom);
`ifdef DMEM_COPY_CSUM_EN
        if (v.len != '0) chk({tag, " csum_clr"}, csum, 0);
`endif
        seen = 0;
        bcnt = 0;
        de   = -1;
        for (int c = 0; c < 3 * int'(v.len) + 20 && !seen; c++) begin
            if (done) begin
                seen = 1;
                de   = ecnt;
            end else begin
                if (busy) bcnt++;
                if (v.noise) start = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        start = v.poke;
        chk({tag, " done_seen"}, 64'(seen), 1);
        chk({tag, " done_lat"}, 64'(de - k), 64'(v.lat));
        chk({tag, " busy_cyc"}, 64'(bcnt), 64'(v.lat));
`ifdef DMEM_COPY_CSUM_EN
        chk({tag, " csum"}, csum, esum);
`endif
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done_pulse"}, {busy, done}, 0);
        @(negedge clk);
        chk({tag, " idle"}, {busy, done, memread, memwrite}, 0);
`ifdef DMEM_COPY_CSUM_EN
        chk({tag, " csum_hold"}, csum, esum);
`endif
        chk({tag, " n_rd"}, 64'(n_rd), 64'(v.len));
        chk({tag, " n_wr"}, 64'(n_wr), 64'(v.len));
        chk({tag, " rw_both"}, 64'(n_both), 0);
        chk({tag, " rd_seq"}, 64'(q_diffs(rd_q, exp_rd)), 0);
        chk({tag, " wr_seq"}, 64'(q_diffs(wr_q, exp_wr)), 0);
        chk({tag, " mem"}, 64'(mem_diffs()), 0);
    endtask

    initial begin
        logic [DW-1:0] r;
        vec_t          v;
        int            t;

        for (int i = 0; i < MSZ; i++) begin
            r = $urandom;
            mem[i] <= r;
            ref_mem[i] = r;
        end
        for (int i = 0; i < 4; i++) begin
            mem[10'h010 + i] <= 32'hA0 + i;
            ref_mem[10'h010 + i] = 32'hA0 + i;
        end

        tbl[0] = '{10'h010, 10'h100, 11'd4,    1'b0, 1'b0, 12};
        tbl[1] = '{10'h000, 10'h050, 11'd0,    1'b1, 1'b1, 0};
        tbl[2] = '{10'h3FE, 10'h001, 11'd3,    1'b0, 1'b0, 9};
        tbl[3] = '{10'h020, 10'h022, 11'd6,    1'b1, 1'b1, 18};
        tbl[4] = '{10'h3F0, 10'h3FC, 11'd10,   1'b1, 1'b0, 30};
        tbl[5] = '{10'h200, 10'h205, 11'd1024, 1'b0, 1'b1, 3072};
        tbl[6] = '{10'h080, 10'h090, 11'd1,    1'b1, 1'b1, 3};

        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start    = 1'($urandom);
            src_addr = AW'($urandom);
            dst_addr = AW'($urandom);
            len      = (AW+1)'($urandom);
        end
        chk("rst_outs", {busy, done, memread, memwrite, address, writedata}, 0);
`ifdef DMEM_COPY_CSUM_EN
        chk("rst_csum", csum, 0);
`endif
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_idle", {busy, done, memread, memwrite}, 0);

        foreach (tbl[i]) run_copy(tbl[i], $sformatf("tbl%0d", i));

        // Reset during an 8-word copy, just after the second write.
        for (int n = 0; n < 2; n++)
            ref_mem[10'h340 + n] = ref_mem[10'h300 + n];
        @(negedge clk);
        clear_mon();
        src_addr = 10'h300;
        dst_addr = 10'h340;
        len      = 11'd8;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (n_wr < 2 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("mid_rst_reach", 64'(n_wr), 2);
        chk("mid_rst_pre_rd", 64'(memread), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {busy, done, memread, memwrite, address, writedata}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_n_wr", 64'(n_wr), 2);
        chk("mid_rst_n_rd", 64'(n_rd), 2);
        chk("mid_rst_mem", 64'(mem_diffs()), 0);

        for (int i = 0; i < 6; i++) begin
            v.src   = AW'($urandom);
            v.dst   = AW'($urandom);
            v.len   = (AW+1)'($urandom_range(0, 40));
            v.noise = 1'b1;
            v.poke  = 1'($urandom);
            v.lat   = 3 * int'(v.len);
            run_copy(v, $sformatf("rnd%0d", i));
        end

`ifdef DMEM_COPY_CSUM_EN
        mem[10'h1A0] <= 32'h1;
        mem[10'h1A1] <= 32'h2;
        mem[10'h1A2] <= 32'h3;
        mem[10'h1A3] <= 32'hFFFFFFFF;
        ref_mem[10'h1A0] = 32'h1;
        ref_mem[10'h1A1] = 32'h2;
        ref_mem[10'h1A2] = 32'h3;
        ref_mem[10'h1A3] = 32'hFFFFFFFF;
        run_copy('{10'h1A0, 10'h1B0, 11'd4, 1'b0, 1'b0, 12}, "csum_seq");
        repeat (3) @(negedge clk);
        chk("csum_fixed", csum, 32'h00000005);
        run_copy('{10'h1B0, 10'h1C0, 11'd1, 1'b0, 1'b0, 3}, "csum_next");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
